// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
// Response codes follow the AXI encoding and are passed through untouched.
package axil_master_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWriteReq,
      StWriteResp,
      StReadReq,
      StReadResp,
      StRespond
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: turns one cmd beat into one AXI
// read or write and returns the captured response on the rsp interface.
module axil_master_bridge
   import axil_master_pkg::*;
#(
   parameter int unsigned AXIL_DATA_WIDTH    = 32,
   parameter int unsigned AXIL_ADDRESS_WIDTH = 4,
   parameter logic [2:0]  AXIL_PROT          = 3'b000
) (
   input  logic                            AXI_clock,
   input  logic                            AXI_reset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [AXIL_ADDRESS_WIDTH-1:0]   cmd_address,
   input  logic [AXIL_DATA_WIDTH-1:0]      cmd_wdata,
   input  logic [AXIL_DATA_WIDTH/8-1:0]    cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [AXIL_DATA_WIDTH-1:0]      rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic [AXIL_ADDRESS_WIDTH-1:0]   AXIL_awaddr,
   output logic [2:0]                      AXIL_awprot,
   output logic                            AXIL_awvalid,
   input  logic                            AXIL_awready,
   output logic [AXIL_DATA_WIDTH-1:0]      AXIL_wdata,
   output logic [AXIL_DATA_WIDTH/8-1:0]    AXIL_wstrb,
   output logic                            AXIL_wvalid,
   input  logic                            AXIL_wready,
   output logic                            AXIL_bready,
   input  logic [1:0]                      AXIL_bresp,
   input  logic                            AXIL_bvalid,
   output logic [AXIL_ADDRESS_WIDTH-1:0]   AXIL_araddr,
   output logic [2:0]                      AXIL_arprot,
   output logic                            AXIL_arvalid,
   input  logic                            AXIL_arready,
   output logic                            AXIL_rready,
   input  logic [AXIL_DATA_WIDTH-1:0]      AXIL_rdata,
   input  logic [1:0]                      AXIL_rresp,
   input  logic                            AXIL_rvalid
);

   localparam int unsigned StrbWidth = AXIL_DATA_WIDTH / 8;

   state_e                          state_q, state_d;
   logic                            cmd_ready_q, cmd_ready_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            arvalid_q, arvalid_d;
   logic                            bready_q, bready_d;
   logic                            rready_q, rready_d;
   logic                            aw_done_q, aw_done_d;
   logic                            w_done_q, w_done_d;
   logic [AXIL_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [AXIL_DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [StrbWidth-1:0]            wstrb_q, wstrb_d;
   logic                            rsp_valid_q, rsp_valid_d;
   logic                            rsp_write_q, rsp_write_d;
   logic [AXIL_DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                      rsp_resp_q, rsp_resp_d;

   logic aw_hs, w_hs;

   assign aw_hs = awvalid_q & AXIL_awready;
   assign w_hs  = wvalid_q & AXIL_wready;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_address;
               if (cmd_write) begin
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = StWriteReq;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StReadReq;
               end
            end
         end
         StWriteReq: begin
            // AW and W complete independently, possibly on the same edge.
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = StWriteResp;
            end
         end
         StWriteResp: begin
            if (AXIL_bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = AXIL_bresp;
               state_d     = StRespond;
            end
         end
         StReadReq: begin
            if (AXIL_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StReadResp;
            end
         end
         StReadResp: begin
            if (AXIL_rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = AXIL_rdata;
               rsp_resp_d  = AXIL_rresp;
               state_d     = StRespond;
            end
         end
         StRespond: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge AXI_clock) begin
      if (AXI_reset) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_write    = rsp_write_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_resp     = rsp_resp_q;
   assign AXIL_awaddr  = addr_q;
   assign AXIL_awprot  = AXIL_PROT;
   assign AXIL_awvalid = awvalid_q;
   assign AXIL_wdata   = wdata_q;
   assign AXIL_wstrb   = wstrb_q;
   assign AXIL_wvalid  = wvalid_q;
   assign AXIL_bready  = bready_q;
   assign AXIL_araddr  = addr_q;
   assign AXIL_arprot  = AXIL_PROT;
   assign AXIL_arvalid = arvalid_q;
   assign AXIL_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench: commands push expected responses computed from a word-array
// model; a monitor pops them as responses arrive. A configurable slave BFM sits on AXI.
module tb_axil_master_bridge;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SW = DW / 8;

   typedef struct {
      logic          write;
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [AW-1:0] cmd_address = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          cmd_ready, rsp_valid, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0;
   logic [1:0]    bresp = 0, rresp = 0;
   logic [DW-1:0] rdata = '0;

   axil_master_bridge #(
      .AXIL_DATA_WIDTH(DW), .AXIL_ADDRESS_WIDTH(AW), .AXIL_PROT(3'b000)
   ) dut (
      .AXI_clock(clk), .AXI_reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .AXIL_awaddr(awaddr), .AXIL_awprot(awprot), .AXIL_awvalid(awvalid),
      .AXIL_awready(awready), .AXIL_wdata(wdata), .AXIL_wstrb(wstrb),
      .AXIL_wvalid(wvalid), .AXIL_wready(wready), .AXIL_bready(bready),
      .AXIL_bresp(bresp), .AXIL_bvalid(bvalid), .AXIL_araddr(araddr),
      .AXIL_arprot(arprot), .AXIL_arvalid(arvalid), .AXIL_arready(arready),
      .AXIL_rready(rready), .AXIL_rdata(rdata), .AXIL_rresp(rresp), .AXIL_rvalid(rvalid)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Slave behaviour knobs, changed only while the bridge is idle.
   int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit         hold_mode = 0, rand_rdy = 0;

   logic [DW-1:0] model_mem [4];
   logic [DW-1:0] slv_mem [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Values as seen by the DUT at each rising edge.
   int            cyc = 0;
   logic          rst_e = 1, aw_hs_e = 0, w_hs_e = 0, ar_hs_e = 0, b_hs_e = 0, r_hs_e = 0;
   logic          awv_e = 0, wv_e = 0, arv_e = 0;
   logic [AW-1:0] awaddr_e = '0, araddr_e = '0;
   logic [DW-1:0] wdata_e = '0;
   logic [SW-1:0] wstrb_e = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_e    <= rst;
      aw_hs_e  <= awvalid && awready;
      w_hs_e   <= wvalid && wready;
      ar_hs_e  <= arvalid && arready;
      b_hs_e   <= bvalid && bready;
      r_hs_e   <= rvalid && rready;
      awv_e    <= awvalid;
      wv_e     <= wvalid;
      arv_e    <= arvalid;
      awaddr_e <= awaddr;
      araddr_e <= araddr;
      wdata_e  <= wdata;
      wstrb_e  <= wstrb;
   end

   // Slave BFM with per-channel ready delays and configurable response codes.
   bit            have_aw = 0, have_w = 0, have_ar = 0, b_pend = 0;
   int            aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [DW-1:0] s_wdata = '0;
   logic [SW-1:0] s_wstrb = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_e) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            have_aw = 0; have_w = 0; have_ar = 0; b_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         end else begin
            if (aw_hs_e) begin have_aw = 1; s_awaddr = awaddr_e; end
            if (w_hs_e) begin have_w = 1; s_wdata = wdata_e; s_wstrb = wstrb_e; end
            if (ar_hs_e) begin have_ar = 1; s_araddr = araddr_e; r_wait = 0; end
            if (b_hs_e) bvalid = 0;
            if (r_hs_e) rvalid = 0;
            if (have_aw && have_w) begin
               for (int i = 0; i < SW; i++)
                  if (s_wstrb[i]) slv_mem[s_awaddr[3:2]][8*i +: 8] = s_wdata[8*i +: 8];
               have_aw = 0; have_w = 0; b_pend = 1; b_wait = 0;
            end
            if (b_pend) begin
               if (b_wait >= b_dly) begin bvalid = 1; bresp = bresp_cfg; b_pend = 0; end
               else b_wait++;
            end
            if (have_ar) begin
               if (r_wait >= r_dly) begin
                  rvalid = 1; rdata = slv_mem[s_araddr[3:2]]; rresp = rresp_cfg; have_ar = 0;
               end else r_wait++;
            end
            awready = awvalid && !have_aw && aw_wait >= aw_dly;
            aw_wait = awvalid ? aw_wait + 1 : 0;
            wready  = wvalid && !have_w && w_wait >= w_dly;
            w_wait  = wvalid ? w_wait + 1 : 0;
            arready = arvalid && ar_wait >= ar_dly;
            ar_wait = arvalid ? ar_wait + 1 : 0;
         end
      end
   end

   // Protocol watcher: held valids, bready/rready ordering, cmd_ready while busy.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_e) begin
            if (awv_e && !aw_hs_e) begin
               check("awvalid_hold", awvalid, 1);
               check("awaddr_hold", awaddr, awaddr_e);
            end
            if (wv_e && !w_hs_e) begin
               check("wvalid_hold", wvalid, 1);
               check("wdata_hold", {wstrb, wdata}, {wstrb_e, wdata_e});
            end
            if (arv_e && !ar_hs_e) begin
               check("arvalid_hold", arvalid, 1);
               check("araddr_hold", araddr, araddr_e);
            end
            if (bready) check("bready_early", {awvalid, wvalid}, 0);
            if (rready) check("rready_early", arvalid, 0);
            if (awvalid || wvalid || arvalid || bready || rready)
               check("cmd_ready_busy", cmd_ready, 0);
         end
      end
   end

   // Response monitor / scoreboard.
   bit            seen = 0, popped = 0;
   int            held = 0;
   logic          snap_w;
   logic [DW-1:0] snap_d;
   logic [1:0]    snap_r;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_e) begin
            seen = 0; popped = 0; rsp_ready = 0;
         end else begin
            if (popped) check("cmd_ready_after_rsp", cmd_ready, 1);
            popped = 0;
            if (rsp_valid) begin
               if (!seen) begin
                  seen = 1; held = 0;
                  snap_w = rsp_write; snap_d = rsp_rdata; snap_r = rsp_resp;
               end else begin
                  check("rsp_stable", {rsp_write, rsp_resp, rsp_rdata}, {snap_w, snap_r, snap_d});
               end
               check("cmd_ready_in_rsp", cmd_ready, 0);
               check("axi_quiet_in_rsp", {awvalid, wvalid, arvalid, bready, rready}, 0);
               if (hold_mode && held < 10) begin
                  rsp_ready = 0; held++;
               end else if (rand_rdy && $urandom_range(0, 2) == 0) begin
                  rsp_ready = 0;
               end else begin
                  rsp_ready = 1;
                  seen = 0; popped = 1;
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_rsp: got write=%0b data=0x%0h, expected none",
                              rsp_write, rsp_rdata);
                  end else begin
                     e = exp_q.pop_front();
                     check("rsp_write", rsp_write, e.write);
                     check("rsp_rdata", rsp_rdata, e.rdata);
                     check("rsp_resp", rsp_resp, e.resp);
                  end
               end
            end else begin
               if (seen) check("rsp_valid_dropped", 0, 1);
               seen = 0; rsp_ready = 0;
            end
         end
      end
   end

   // Returns at the sampling phase just after the accepting edge; e0 = cyc there.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input bit track, output int e0);
      exp_t e;
      int   n = 0;
      cmd_valid = 1; cmd_write = w; cmd_address = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", cmd_ready, 1);
         cmd_valid = 0;
         e0 = cyc;
         return;
      end
      @(posedge clk);
      #1;
      e0 = cyc;
      cmd_valid = 0;
      if (track) begin
         e.write = w;
         if (w) begin
            for (int i = 0; i < SW; i++)
               if (s[i]) model_mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
            e.rdata = '0;
            e.resp  = bresp_cfg;
         end else begin
            e.rdata = model_mem[a[3:2]];
            e.resp  = rresp_cfg;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !cmd_ready || rsp_valid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", n < 2000, 1);
   endtask

   initial begin
      int e0, first_k, ar_cnt, aw_cnt, w_cnt;
      for (int i = 0; i < 4; i++) begin model_mem[i] = '0; slv_mem[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      check("reset_data", {rsp_rdata, rsp_resp, rsp_write, awaddr, araddr, wdata, wstrb}, 0);
      rst = 0;

      // Write then read back through the slave.
      issue(1, 4'h4, 32'hDEADBEEF, 4'hF, 1, e0);
      wait_idle();
      issue(0, 4'h4, '0, '0, 1, e0);
      wait_idle();

      // Zero-wait read latency: arvalid sampled on exactly one edge, rsp_valid by E0+3.
      issue(0, 4'h8, '0, '0, 1, e0);
      first_k = -1; ar_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (arvalid) ar_cnt++;
         if (rsp_valid && first_k < 0) first_k = k;
         @(posedge clk);
         #1;
      end
      check("arvalid_cycles", ar_cnt, 1);
      check("rsp_valid_edge", first_k + 1, 3);
      wait_idle();

      // AW stalled five cycles, W immediate.
      aw_dly = 5;
      issue(1, 4'hC, 32'hA5A5_0F0F, 4'hF, 1, e0);
      aw_cnt = 0; w_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (awvalid) aw_cnt++;
         if (wvalid) w_cnt++;
         @(posedge clk);
         #1;
      end
      check("awvalid_cycles", aw_cnt, 6);
      check("wvalid_cycles", w_cnt, 1);
      wait_idle();
      aw_dly = 0;

      // Error responses pass through.
      bresp_cfg = 2'b10;
      issue(1, 4'h0, 32'h1111_2222, 4'h3, 1, e0);
      wait_idle();
      bresp_cfg = 2'b00; rresp_cfg = 2'b11;
      issue(0, 4'h0, '0, '0, 1, e0);
      wait_idle();
      rresp_cfg = 2'b00;
      check("idle_after_err", cmd_ready, 1);

      // Response back-pressure for 10 cycles.
      issue(1, 4'h0, 32'h12345678, 4'hF, 1, e0);
      wait_idle();
      hold_mode = 1;
      issue(0, 4'h0, '0, '0, 1, e0);
      wait_idle();
      hold_mode = 0;
      check("hold_cycles", held, 10);

      // Reset while AW is stalled aborts without a response.
      aw_dly = 30;
      issue(1, 4'h8, 32'hBAD0_BAD0, 4'hF, 0, e0);
      @(posedge clk);
      #1;
      check("awvalid_before_reset", awvalid, 1);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      check("abort_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      aw_dly = 0;
      issue(0, 4'h8, '0, '0, 1, e0);
      wait_idle();

      // Randomized traffic with random delays, codes and rsp_ready back-pressure.
      rand_rdy = 1;
      for (int t = 0; t < 40; t++) begin
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         r_dly  = $urandom_range(0, 3);
         bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom),
               SW'($urandom_range(0, 15)), 1, e0);
         wait_idle();
      end
      rand_rdy = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
